// File: rtl/prim_clock_gate_ctrl_pkg.sv
// Shared types and helpers for the clock-gate enable controller.
package prim_clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REQ   = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } gate_state_e;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/prim_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered at-max flag.
module prim_sat_counter #(
  parameter int unsigned     Width  = 4,
  parameter logic [Width-1:0] MaxVal = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             at_max_o
);

  logic [Width-1:0] cnt_d, cnt_q;
  logic             at_max_d, at_max_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + Width'(1);
    end
    at_max_d = (cnt_d == MaxVal);
  end

  // at_max tracks the register so downstream decode needs no compare.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      at_max_q <= (MaxVal == '0);
    end else begin
      cnt_q    <= cnt_d;
      at_max_q <= at_max_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = at_max_q;

endmodule

// File: rtl/prim_clock_gate_ctrl.sv
// Enable controller for a downstream clock-gating cell: idle detect, quiesce handshake, wake settle.
// Optional gated-cycle statistics counter: define PRIM_CLOCK_GATE_CTRL_STATS_EN.
module prim_clock_gate_ctrl
  import prim_clock_gate_ctrl_pkg::*;
#(
  parameter int unsigned IdleCycles = 16,
  parameter int unsigned WakeCycles = 2,
  parameter int unsigned CntW       = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            activity_i,
  input  logic            wake_req_i,
  input  logic            quiesce_ack_i,
  output logic            quiesce_req_o,
  output logic            en_o,
  output logic            ready_o,
  output logic [1:0]      state_o
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
  ,
  output logic [CntW-1:0] gated_cycles_o
`endif
);

  localparam int unsigned IdleW = cnt_width(IdleCycles);
  localparam int unsigned WakeW = cnt_width(WakeCycles);

  if (IdleCycles == 0) begin : g_bad_idle
    $error("prim_clock_gate_ctrl: IdleCycles must be >= 1");
  end
  if (WakeCycles == 0) begin : g_bad_wake
    $error("prim_clock_gate_ctrl: WakeCycles must be >= 1");
  end
  if (CntW == 0) begin : g_bad_cntw
    $error("prim_clock_gate_ctrl: CntW must be >= 1");
  end

  gate_state_e state_d, state_q;
  logic        en_d, en_q;
  logic        ready_d, ready_q;
  logic        qreq_d, qreq_q;

  logic             busy;
  logic             idle_clr, idle_inc;
  logic             wake_clr, wake_inc;
  logic [IdleW-1:0] idle_cnt;
  logic             idle_at_max_unused;
  logic [WakeW-1:0] wake_cnt_unused;
  logic             wake_done;

  assign busy = activity_i | wake_req_i;

  // Idle counter only runs in RUN; held at zero elsewhere so every RUN entry starts fresh.
  prim_sat_counter #(
    .Width  (IdleW),
    .MaxVal (IdleW'(IdleCycles))
  ) u_idle_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (idle_clr),
    .inc_i    (idle_inc),
    .cnt_o    (idle_cnt),
    .at_max_o (idle_at_max_unused)
  );

  // Wake counter's at-max flag marks the last settle cycle.
  prim_sat_counter #(
    .Width  (WakeW),
    .MaxVal (WakeW'(WakeCycles - 1))
  ) u_wake_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wake_clr),
    .inc_i    (wake_inc),
    .cnt_o    (wake_cnt_unused),
    .at_max_o (wake_done)
  );

  always_comb begin
    state_d  = state_q;
    idle_clr = 1'b1;
    idle_inc = 1'b0;
    wake_clr = 1'b1;
    wake_inc = 1'b0;
    en_d     = 1'b1;
    ready_d  = 1'b1;
    qreq_d   = 1'b0;

    unique case (state_q)
      RUN: begin
        idle_clr = busy;
        idle_inc = ~busy;
        if (!busy && (idle_cnt == IdleW'(IdleCycles - 1))) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (busy) begin
          state_d = RUN;
        end else if (quiesce_ack_i) begin
          state_d = GATED;
        end
      end
      GATED: begin
        if (busy) begin
          state_d = WAKE;
        end
      end
      WAKE: begin
        wake_clr = 1'b0;
        wake_inc = 1'b1;
        if (wake_done) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Outputs come from the next state so they land in flops alongside it.
    en_d    = (state_d != GATED);
    ready_d = (state_d == RUN) || (state_d == REQ);
    qreq_d  = (state_d == REQ) || (state_d == GATED);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      en_q    <= 1'b1;
      ready_q <= 1'b1;
      qreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      qreq_q  <= qreq_d;
    end
  end

  assign en_o          = en_q;
  assign ready_o       = ready_q;
  assign quiesce_req_o = qreq_q;
  assign state_o       = state_q;

`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
  logic stats_at_max_unused;

  // Counts cycles spent gated; only reset clears it.
  prim_sat_counter #(
    .Width (CntW)
  ) u_stats_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (1'b0),
    .inc_i    (state_q == GATED),
    .cnt_o    (gated_cycles_o),
    .at_max_o (stats_at_max_unused)
  );
`endif

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Self-checking bench for prim_clock_gate_ctrl: vector table, corner sequences, random vs reference model.
module tb_prim_clock_gate_ctrl;

  localparam int unsigned IdleCycles = 4;
  localparam int unsigned WakeCycles = 2;
  localparam int unsigned CntW       = 4;
  localparam int          StatMax    = (1 << CntW) - 1;

  logic       clk = 1'b0;
  logic       rst_i, activity_i, wake_req_i, quiesce_ack_i;
  logic       quiesce_req_o, en_o, ready_o;
  logic [1:0] state_o;
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
  logic [CntW-1:0] gated_cycles_o;
`endif

  always #5 clk = ~clk;

  prim_clock_gate_ctrl #(
    .IdleCycles (IdleCycles),
    .WakeCycles (WakeCycles),
    .CntW       (CntW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .activity_i     (activity_i),
    .wake_req_i     (wake_req_i),
    .quiesce_ack_i  (quiesce_ack_i),
    .quiesce_req_o  (quiesce_req_o),
    .en_o           (en_o),
    .ready_o        (ready_o),
    .state_o        (state_o)
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    ,
    .gated_cycles_o (gated_cycles_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counts of idle cycles, pending request, gated flag, settle cycles left.
  int m_streak    = 0;
  bit m_req       = 1'b0;
  bit m_gated     = 1'b0;
  int m_wake_left = 0;
  int m_gcnt      = 0;

  task automatic model_step(input bit r, input bit a, input bit w, input bit k);
    bit b;
    b = a | w;
    if (r) begin
      m_streak = 0; m_req = 1'b0; m_gated = 1'b0; m_wake_left = 0; m_gcnt = 0;
    end else begin
      if (m_gated && m_gcnt < StatMax) m_gcnt++;
      if (m_gated) begin
        if (b) begin
          m_gated     = 1'b0;
          m_wake_left = WakeCycles;
        end
      end else if (m_wake_left > 0) begin
        m_wake_left--;
        if (m_wake_left == 0) m_streak = 0;
      end else if (m_req) begin
        if (b) begin
          m_req = 1'b0; m_streak = 0;
        end else if (k) begin
          m_req = 1'b0; m_gated = 1'b1;
        end
      end else begin
        m_streak = b ? 0 : m_streak + 1;
        if (m_streak == IdleCycles) begin
          m_req = 1'b1; m_streak = 0;
        end
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    logic [1:0] st;
    st = m_gated ? 2'd2 : (m_wake_left > 0) ? 2'd3 : m_req ? 2'd1 : 2'd0;
    return {st, !m_gated, (!m_gated && m_wake_left == 0), (m_req || m_gated)};
  endfunction

  function automatic logic [4:0] dut_out();
    return {state_o, en_o, ready_o, quiesce_req_o};
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h required 0x%0h", name, idx, got, exp);
    end
  endtask

  // Drive inputs, take one clock edge, step the model, sample #1 later.
  task automatic cycle(input bit r, input bit a, input bit w, input bit k);
    rst_i = r; activity_i = a; wake_req_i = w; quiesce_ack_i = k;
    @(posedge clk);
    model_step(r, a, w, k);
    #1;
  endtask

  typedef struct {
    bit         rst, act, wake, ack;
    logic [1:0] st;
    bit         en, rdy, qreq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit a, input bit w, input bit k,
                     input logic [1:0] st, input bit en, input bit rdy, input bit q);
    vec_t v;
    v.rst = r; v.act = a; v.wake = w; v.ack = k;
    v.st = st; v.en = en; v.rdy = rdy; v.qreq = q;
    vecs.push_back(v);
  endtask

  initial begin
    rst_i = 1'b1; activity_i = 1'b0; wake_req_i = 1'b0; quiesce_ack_i = 1'b0;

    // rst act wake ack | state en rdy qreq
    add(1, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd1, 1, 1, 1);
    add(0, 0, 0, 1, 2'd2, 0, 0, 1);
    add(0, 0, 0, 1, 2'd2, 0, 0, 1);
    add(0, 0, 1, 0, 2'd3, 1, 0, 0);
    add(0, 1, 0, 0, 2'd3, 1, 0, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 1, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 1, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd1, 1, 1, 1);
    add(0, 1, 0, 1, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd1, 1, 1, 1);
    add(0, 0, 0, 1, 2'd2, 0, 0, 1);
    add(1, 0, 0, 0, 2'd0, 1, 1, 0);
    add(0, 0, 0, 0, 2'd0, 1, 1, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].act, vecs[i].wake, vecs[i].ack);
      check("vec", i, 32'(dut_out()),
            32'({vecs[i].st, vecs[i].en, vecs[i].rdy, vecs[i].qreq}));
    end

    // Gate, then wake through activity_i and time the settle window.
    cycle(0, 1, 0, 0);
    for (int i = 0; i < IdleCycles - 1; i++) cycle(0, 0, 0, 0);
    check("pre_req_state", 0, 32'(state_o), 32'd0);
    cycle(0, 0, 0, 0);
    check("req_state", 0, 32'(state_o), 32'd1);
    cycle(0, 0, 0, 1);
    check("gated_en", 0, 32'(en_o), 32'd0);
    cycle(0, 1, 0, 0);
    check("wake_en", 0, 32'(en_o), 32'd1);
    check("wake_qreq", 0, 32'(quiesce_req_o), 32'd0);
    check("wake_ready", 0, 32'(ready_o), 32'd0);
    for (int k = 1; k < WakeCycles; k++) begin
      cycle(0, 0, 0, 1);
      check("wake_ready", k, 32'(ready_o), 32'd0);
    end
    cycle(0, 0, 0, 0);
    check("settled_ready", 0, 32'(ready_o), 32'd1);
    check("settled_state", 0, 32'(state_o), 32'd0);
    check("model_sync", 0, 32'(dut_out()), 32'(model_out()));

`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    // Gated-cycle counter saturates and survives a wake/re-gate round trip.
    cycle(1, 0, 0, 0);
    check("stats_reset", 0, 32'(gated_cycles_o), 32'd0);
    for (int i = 0; i < IdleCycles; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
    check("stats_sat", 0, 32'(gated_cycles_o), 32'(StatMax));
    cycle(0, 0, 1, 0);
    for (int i = 0; i < WakeCycles + IdleCycles; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check("stats_regate", 0, 32'(gated_cycles_o), 32'(StatMax));
`endif

    // Random traffic against the reference model.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, a, w, k;
      r = ($urandom_range(0, 99) == 0);
      a = ($urandom_range(0, 9) == 0);
      w = ($urandom_range(0, 19) == 0);
      k = ($urandom_range(0, 2) == 0);
      cycle(r, a, w, k);
      check("rand", i, 32'(dut_out()), 32'(model_out()));
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
      check("rand_stats", i, 32'(gated_cycles_o), 32'(m_gcnt));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
